// File: rtl/painel_varredura_pkg.sv
// Shared constants and types for the 7x5 LED panel row-scan controller.
package painel_varredura_pkg;

    // Select code the row multiplexers map to an all-off output.
    localparam logic [2:0] SEL_BLANK = 3'b111;

    localparam int unsigned NUM_ROWS = 7;
    localparam int unsigned NUM_COLS = 5;
    localparam int unsigned ROW_W    = 3;

    // One column pattern; bit 6 is the top row.
    typedef logic [NUM_ROWS-1:0] col_t;

endpackage

// File: rtl/painel_prescaler.sv
// Row-slot prescaler: counts 0..DIV-1 while enabled and flags the last count.
module painel_prescaler #(
    parameter int unsigned DIV   = 1000,
    parameter int unsigned CNT_W = $clog2(DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q;

    // Counter state: clear wins over enable, wraps after the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Tick marks the final cycle of a row slot.
    always_comb begin
        tick  = en && !clr && (count_q == LAST);
        count = count_q;
    end

endmodule

// File: rtl/painel_varredura.sv
// Row-scan controller: double-buffered 5-column frame, row sequencing with
// blanking between rows, and frame-aligned shadow-to-active commit.
module painel_varredura
    import painel_varredura_pkg::*;
#(
    parameter int unsigned DIV   = 1000,
    parameter int unsigned BLANK = 16,
    parameter int unsigned COLS  = NUM_COLS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [2:0]               wr_col,
    input  logic [NUM_ROWS-1:0]      wr_data,
    input  logic                     commit,
    output logic                     commit_done,
    output logic                     wr_err,
    output logic                     sel1,
    output logic                     sel2,
    output logic                     sel3,
    output logic [NUM_ROWS*COLS-1:0] linhas,
    output logic                     frame_start
);

    localparam int unsigned        CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0]   BLANK_C  = CNT_W'(BLANK);
    localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [2:0]         MAX_COL  = 3'(COLS - 1);

    logic                     tick;
    logic [CNT_W-1:0]         count;
    logic [ROW_W-1:0]         row_q;
    logic [2:0]               sel_q;
    logic                     frame_start_q;
    logic                     pending_q;
    logic                     commit_done_q;
    logic                     wr_err_q;
    logic [NUM_ROWS*COLS-1:0] shadow_q;
    logic [NUM_ROWS*COLS-1:0] linhas_q;

    logic frame_wrap;
    logic scan_blank;
    logic copy;
    logic wr_fire;
    logic col_ok;

    painel_prescaler #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (!en),
        .tick  (tick),
        .count (count)
    );

    // Frame boundary, blanking window, write transfer and copy decisions.
    always_comb begin
        frame_wrap = tick && (row_q == LAST_ROW);
        scan_blank = !en || (count < BLANK_C);
        // With scanning stopped there is no frame to protect, so copy at once.
        copy       = pending_q && (frame_wrap || !en);
        wr_fire    = wr_valid && !pending_q;
        col_ok     = (wr_col <= MAX_COL);
    end

    // Row counter, registered select and frame-start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q         <= '0;
            sel_q         <= SEL_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            sel_q         <= scan_blank ? SEL_BLANK : row_q;
            frame_start_q <= frame_wrap;
            if (!en) begin
                row_q <= '0;
            end else if (tick) begin
                row_q <= (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
            end
        end
    end

    // Shadow writes, commit request and frame-aligned copy to the active buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            linhas_q      <= '0;
            pending_q     <= 1'b0;
            commit_done_q <= 1'b0;
            wr_err_q      <= 1'b0;
        end else begin
            wr_err_q      <= wr_fire && !col_ok;
            commit_done_q <= copy;
            for (int c = 0; c < COLS; c++) begin
                if (wr_fire && (wr_col == 3'(c))) begin
                    shadow_q[c*NUM_ROWS +: NUM_ROWS] <= wr_data;
                end
            end
            // copy and wr_fire are exclusive: one needs pending, the other not.
            if (copy) begin
                linhas_q  <= shadow_q;
                pending_q <= 1'b0;
            end else if (commit) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Output mapping.
    always_comb begin
        wr_ready    = !pending_q;
        commit_done = commit_done_q;
        wr_err      = wr_err_q;
        sel1        = sel_q[2];
        sel2        = sel_q[1];
        sel3        = sel_q[0];
        linhas      = linhas_q;
        frame_start = frame_start_q;
    end

endmodule

// File: tb/tb_painel_varredura.sv
// Randomised self-checking bench for painel_varredura against a phase-based
// reference model of the panel scan and commit protocol.
module tb_painel_varredura;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int NROWS = 7;
    localparam logic [34:0] FRAME_A = {7'h55, 7'h2A, 7'h40, 7'h01, 7'h7F};
    localparam logic [34:0] FRAME_B = {7'h55, 7'h2A, 7'h33, 7'h01, 7'h7F};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_col;
    logic [6:0]  wr_data;
    logic        commit;
    logic        commit_done;
    logic        wr_err;
    logic        sel1;
    logic        sel2;
    logic        sel3;
    logic [34:0] linhas;
    logic        frame_start;

    painel_varredura #(
        .DIV   (DIV),
        .BLANK (BLANK),
        .COLS  (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .commit      (commit),
        .commit_done (commit_done),
        .wr_err      (wr_err),
        .sel1        (sel1),
        .sel2        (sel2),
        .sel3        (sel3),
        .linhas      (linhas),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position within the frame as a single phase number.
    int          m_phase;
    logic [2:0]  m_sel;
    logic        m_fs;
    logic        m_cd;
    logic        m_err;
    logic        m_pending;
    logic [34:0] m_shadow;
    logic [34:0] m_active;

    task automatic check_eq(input string tag, input logic [34:0] got, input logic [34:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_phase   = 0;
        m_sel     = 3'b111;
        m_fs      = 1'b0;
        m_cd      = 1'b0;
        m_err     = 1'b0;
        m_pending = 1'b0;
        m_shadow  = '0;
        m_active  = '0;
    endtask

    task automatic check_outputs();
        check_eq("sel", 35'({sel1, sel2, sel3}), 35'(m_sel));
        check_eq("frame_start", 35'(frame_start), 35'(m_fs));
        check_eq("commit_done", 35'(commit_done), 35'(m_cd));
        check_eq("wr_err", 35'(wr_err), 35'(m_err));
        check_eq("wr_ready", 35'(wr_ready), 35'(!m_pending));
        check_eq("linhas", linhas, m_active);
    endtask

    // Called at a falling edge: check, drive this cycle's inputs, advance model.
    task automatic step(input logic e, input logic wv, input logic [2:0] col,
                        input logic [6:0] d, input logic cm);
        int   pre;
        int   row;
        logic tick;
        logic wrap;
        logic copy;
        logic fire;
        check_outputs();
        en       = e;
        wr_valid = wv;
        wr_col   = col;
        wr_data  = d;
        commit   = cm;
        pre  = m_phase % DIV;
        row  = m_phase / DIV;
        tick = e && (pre == DIV - 1);
        wrap = tick && (row == NROWS - 1);
        m_sel = (!e || pre < BLANK) ? 3'b111 : 3'(row);
        m_fs  = wrap;
        copy  = m_pending && (wrap || !e);
        m_cd  = copy;
        fire  = wv && !m_pending;
        m_err = fire && (col >= 3'd5);
        if (copy) m_active = m_shadow;
        if (fire && col < 3'd5) m_shadow[int'(col)*7 +: 7] = d;
        if (copy) m_pending = 1'b0;
        else if (cm) m_pending = 1'b1;
        m_phase = e ? (m_phase + 1) % (NROWS * DIV) : 0;
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic e);
        for (int i = 0; i < n; i++) step(e, 1'b0, 3'd0, 7'd0, 1'b0);
    endtask

    initial begin
        int guard;
        rst_n    = 1'b0;
        en       = 1'b0;
        wr_valid = 1'b0;
        wr_col   = 3'd0;
        wr_data  = 7'd0;
        commit   = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Free-running scan, then fill the shadow and commit mid-frame.
        run(10, 1'b1);
        step(1'b1, 1'b1, 3'd0, 7'h7F, 1'b0);
        step(1'b1, 1'b1, 3'd1, 7'h01, 1'b0);
        step(1'b1, 1'b1, 3'd2, 7'h40, 1'b0);
        step(1'b1, 1'b1, 3'd3, 7'h2A, 1'b0);
        step(1'b1, 1'b1, 3'd4, 7'h55, 1'b0);
        step(1'b1, 1'b0, 3'd0, 7'h00, 1'b1);
        run(35, 1'b1);
        check_eq("frame_a", linhas, FRAME_A);

        // Out-of-range column must leave the shadow alone.
        step(1'b1, 1'b1, 3'd6, 7'h7F, 1'b0);
        step(1'b1, 1'b0, 3'd0, 7'h00, 1'b1);
        run(35, 1'b1);
        check_eq("frame_keep", linhas, FRAME_A);

        // Pending commit while scanning is stopped copies at once.
        step(1'b1, 1'b1, 3'd2, 7'h33, 1'b0);
        step(1'b1, 1'b0, 3'd0, 7'h00, 1'b1);
        run(4, 1'b0);
        check_eq("frame_b", linhas, FRAME_B);

        // Commit and write held high across a pending period.
        run(5, 1'b1);
        for (int i = 0; i < 35; i++) step(1'b1, 1'b1, 3'd3, 7'h11, 1'b1);
        run(35, 1'b1);

        // Reset while row 3 is being scanned with a commit pending.
        guard = 0;
        while (!(m_phase / DIV == 3 && m_pending) && guard < 80) begin
            step(1'b1, 1'b0, 3'd0, 7'h00, 1'b1);
            guard++;
        end
        check_eq("reach_row3", 35'(guard < 80), 35'(1));
        check_outputs();
        rst_n = 1'b0;
        #1;
        check_eq("rst_sel", 35'({sel1, sel2, sel3}), 35'(3'b111));
        check_eq("rst_linhas", linhas, 35'd0);
        check_eq("rst_ready", 35'(wr_ready), 35'(1));
        check_eq("rst_done", 35'(commit_done), 35'(0));
        en     = 1'b0;
        commit = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(40, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(15) != 0), ($urandom_range(1) == 1),
                 3'($urandom_range(7)), 7'($urandom), ($urandom_range(19) == 0));
        end
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
